// File: rtl/axis_pkt_arbiter.sv
// rtl/axis_pkt_arbiter.sv - packet-granular round-robin arbiter for the shared AXIS egress
//
// Purpose: shares one AXI-Stream egress among NUM_SRC sources. One source is granted at a
// time and keeps the grant until its TLAST beat is accepted. Every packet costs exactly one
// idle arbitration cycle.
//
// Ports:
//   ACLK, ARESET          clock, synchronous active-high reset
//   SRC_EN                per-source enable, only looked at while idle
//   S_AXIS_DAT_*          NUM_SRC packed source streams (source i at slice i)
//   M_AXIS_DAT_*          muxed egress stream
//   GRANT_VLD/GRANT_IDX   grant status (index is meaningful while GRANT_VLD=1)
//   PKT_DONE              one-cycle pulse the cycle after a TLAST handshake
//   OVERLONG              sticky per-source flag: a packet ran past MAX_BEATS beats
module axis_pkt_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int DATA_W    = 32,
  parameter int USER_W    = 8,
  parameter int MAX_BEATS = 4096
) (
  input  logic                         ACLK,
  input  logic                         ARESET,
  input  logic [NUM_SRC-1:0]           SRC_EN,
  input  logic [NUM_SRC*DATA_W-1:0]    S_AXIS_DAT_TDATA,
  input  logic [NUM_SRC*DATA_W/8-1:0]  S_AXIS_DAT_TSTRB,
  input  logic [NUM_SRC*USER_W-1:0]    S_AXIS_DAT_TUSER,
  input  logic [NUM_SRC-1:0]           S_AXIS_DAT_TLAST,
  input  logic [NUM_SRC-1:0]           S_AXIS_DAT_TVALID,
  output logic [NUM_SRC-1:0]           S_AXIS_DAT_TREADY,
  output logic [DATA_W-1:0]            M_AXIS_DAT_TDATA,
  output logic [DATA_W/8-1:0]          M_AXIS_DAT_TSTRB,
  output logic [USER_W-1:0]            M_AXIS_DAT_TUSER,
  output logic                         M_AXIS_DAT_TLAST,
  output logic                         M_AXIS_DAT_TVALID,
  input  logic                         M_AXIS_DAT_TREADY,
  output logic                         GRANT_VLD,
  output logic [2:0]                   GRANT_IDX,
  output logic                         PKT_DONE,
  output logic [NUM_SRC-1:0]           OVERLONG
);

  localparam int STRB_W = DATA_W / 8;
  // Counter must hold MAX_BEATS+1 so that the saturated value still reads as "too long".
  localparam int CNT_W = $clog2(MAX_BEATS + 2);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BEATS);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_BEATS + 1);

  typedef enum logic {ST_IDLE, ST_XFER} state_t;

  state_t             state_q, state_d;
  logic [2:0]         grant_q, grant_d;
  logic [2:0]         last_grant_q, last_grant_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic               pkt_done_q, pkt_done_d;
  logic [NUM_SRC-1:0] overlong_q, overlong_d;

  logic               xfer;
  logic [NUM_SRC-1:0] sel;
  logic [NUM_SRC-1:0] req;
  logic               g_valid;
  logic               g_last;
  logic               hs;
  logic               found;
  logic [2:0]         rr_idx;
  logic [DATA_W-1:0]  mux_data;
  logic [STRB_W-1:0]  mux_strb;
  logic [USER_W-1:0]  mux_user;

  assign xfer = (state_q == ST_XFER);
  assign req  = S_AXIS_DAT_TVALID & SRC_EN;

  // One-hot decode of the current grant; drives both the mux and the ready fan-out.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      sel[i] = (grant_q == 3'(i));
    end
  end

  always_comb begin
    mux_data = '0;
    mux_strb = '0;
    mux_user = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (sel[i]) begin
        mux_data = S_AXIS_DAT_TDATA[i*DATA_W +: DATA_W];
        mux_strb = S_AXIS_DAT_TSTRB[i*STRB_W +: STRB_W];
        mux_user = S_AXIS_DAT_TUSER[i*USER_W +: USER_W];
      end
    end
  end

  assign g_valid = |(sel & S_AXIS_DAT_TVALID);
  assign g_last  = |(sel & S_AXIS_DAT_TLAST);
  assign hs      = xfer & g_valid & M_AXIS_DAT_TREADY;

  assign M_AXIS_DAT_TDATA  = mux_data;
  assign M_AXIS_DAT_TSTRB  = mux_strb;
  assign M_AXIS_DAT_TUSER  = mux_user;
  assign M_AXIS_DAT_TLAST  = g_last;
  // TVALID depends only on the state flop and the granted source, never on egress TREADY.
  assign M_AXIS_DAT_TVALID = xfer & g_valid;
  assign S_AXIS_DAT_TREADY = {NUM_SRC{xfer & M_AXIS_DAT_TREADY}} & sel;

  // Round-robin search starting one past the last completed grant, wrapping at NUM_SRC.
  always_comb begin
    int cand;
    found  = 1'b0;
    rr_idx = last_grant_q;
    cand   = 0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = int'(last_grant_q) + k;
      if (cand >= NUM_SRC) cand = cand - NUM_SRC;
      if (!found && req[cand]) begin
        found  = 1'b1;
        rr_idx = 3'(cand);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    pkt_done_d   = 1'b0;
    overlong_d   = overlong_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          grant_d = rr_idx;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        if (hs) begin
          // This beat pushes the count past MAX_BEATS; flag it but keep transferring.
          if (beat_cnt_q >= CNT_MAX) overlong_d = overlong_q | sel;
          if (g_last) begin
            last_grant_d = grant_q;
            beat_cnt_d   = '0;
            pkt_done_d   = 1'b1;
            state_d      = ST_IDLE;
          end else if (beat_cnt_q != CNT_SAT) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= 3'(NUM_SRC - 1);
      beat_cnt_q   <= '0;
      pkt_done_q   <= 1'b0;
      overlong_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      pkt_done_q   <= pkt_done_d;
      overlong_q   <= overlong_d;
    end
  end

  assign GRANT_VLD = xfer;
  assign GRANT_IDX = grant_q;
  assign PKT_DONE  = pkt_done_q;
  assign OVERLONG  = overlong_q;

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// tb/tb_axis_pkt_arbiter.sv - self-checking bench for axis_pkt_arbiter
module tb_axis_pkt_arbiter;
  localparam int NS = 4, DW = 32, UW = 8, SW = 4, MAXB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            areset;
  logic [NS-1:0]   src_en, s_tvalid, s_tlast, s_tready;
  logic [NS*DW-1:0] s_tdata;
  logic [NS*SW-1:0] s_tstrb;
  logic [NS*UW-1:0] s_tuser;
  logic [DW-1:0]   m_tdata;
  logic [SW-1:0]   m_tstrb;
  logic [UW-1:0]   m_tuser;
  logic            m_tlast, m_tvalid, m_tready;
  logic            gvld, pkt_done;
  logic [2:0]      gidx;
  logic [NS-1:0]   overlong;

  axis_pkt_arbiter #(.NUM_SRC(NS), .DATA_W(DW), .USER_W(UW), .MAX_BEATS(MAXB)) dut (
    .ACLK(clk), .ARESET(areset), .SRC_EN(src_en),
    .S_AXIS_DAT_TDATA(s_tdata), .S_AXIS_DAT_TSTRB(s_tstrb), .S_AXIS_DAT_TUSER(s_tuser),
    .S_AXIS_DAT_TLAST(s_tlast), .S_AXIS_DAT_TVALID(s_tvalid), .S_AXIS_DAT_TREADY(s_tready),
    .M_AXIS_DAT_TDATA(m_tdata), .M_AXIS_DAT_TSTRB(m_tstrb), .M_AXIS_DAT_TUSER(m_tuser),
    .M_AXIS_DAT_TLAST(m_tlast), .M_AXIS_DAT_TVALID(m_tvalid), .M_AXIS_DAT_TREADY(m_tready),
    .GRANT_VLD(gvld), .GRANT_IDX(gidx), .PKT_DONE(pkt_done), .OVERLONG(overlong)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    logic [UW-1:0] u;
    logic          l;
  } beat_t;

  typedef struct {
    logic       rdy;
    logic       vld;
    logic [2:0] idx;
    logic       cidx;
    logic       done;
  } vec_t;

  beat_t srcq [NS][$];
  int total = 0, bad = 0;

  // Reference model: which source owns the egress, where round-robin resumes, beats so far.
  bit          m_xfer, m_done, gaps;
  int          m_g, m_last, m_cnt;
  logic [NS-1:0] m_over;

  bit            hs_now;
  int            hs_src;
  logic [DW-1:0] hs_data;
  logic          s_gvld, s_done;
  logic [2:0]    s_gidx;
  logic [NS-1:0] s_over, s_trdy;
  logic [NS-1:0] pop;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  function automatic int rr_pick(input int last, input logic [NS-1:0] req);
    for (int k = 1; k <= NS; k++) begin
      if (req[(last + k) % NS]) return (last + k) % NS;
    end
    return -1;
  endfunction

  function automatic bit all_empty();
    for (int i = 0; i < NS; i++) if (srcq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic add_pkt(input int src, input int len, input logic [DW-1:0] base);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.d = base + DW'(k);
      b.s = SW'($urandom);
      b.u = UW'($urandom);
      b.l = (k == len - 1);
      srcq[src].push_back(b);
    end
  endtask

  task automatic drive_srcs();
    beat_t b;
    for (int i = 0; i < NS; i++) begin
      if (srcq[i].size() > 0 && (!gaps || $urandom_range(3) != 0)) begin
        b = srcq[i][0];
        s_tvalid[i] = 1'b1;
        s_tlast[i]  = b.l;
        s_tdata[i*DW +: DW] = b.d;
        s_tstrb[i*SW +: SW] = b.s;
        s_tuser[i*UW +: UW] = b.u;
      end else begin
        s_tvalid[i] = 1'b0;
        s_tlast[i]  = 1'b0;
        s_tdata[i*DW +: DW] = '0;
        s_tstrb[i*SW +: SW] = '0;
        s_tuser[i*UW +: UW] = '0;
      end
    end
  endtask

  // One clock: sample and check at negedge, then update sources just after posedge.
  task automatic cyc();
    beat_t b;
    logic [NS-1:0] er;
    logic [NS-1:0] req;
    @(negedge clk);
    pop    = '0;
    hs_now = 1'b0;
    s_gvld = gvld; s_gidx = gidx; s_done = pkt_done; s_over = overlong; s_trdy = s_tready;
    if (areset) begin
      m_xfer = 1'b0; m_done = 1'b0; m_last = NS - 1; m_cnt = 0; m_over = '0; m_g = 0;
    end else begin
      chk("grant_vld", 64'(gvld), 64'(m_xfer));
      if (m_xfer) chk("grant_idx", 64'(gidx), 64'(m_g));
      chk("pkt_done", 64'(pkt_done), 64'(m_done));
      chk("overlong", 64'(overlong), 64'(m_over));
      m_done = 1'b0;
      if (!m_xfer) begin
        chk("idle_mvalid", 64'(m_tvalid), 64'd0);
        chk("idle_sready", 64'(s_tready), 64'd0);
        req = s_tvalid & src_en;
        if (req != '0) begin
          m_g    = rr_pick(m_last, req);
          m_xfer = 1'b1;
        end
      end else begin
        er = '0;
        if (m_tready) er[m_g] = 1'b1;
        chk("xfer_sready", 64'(s_tready), 64'(er));
        chk("xfer_mvalid", 64'(m_tvalid), 64'(s_tvalid[m_g]));
        if (s_tvalid[m_g]) begin
          b = srcq[m_g][0];
          chk("mux_data", 64'(m_tdata), 64'(b.d));
          chk("mux_strb", 64'(m_tstrb), 64'(b.s));
          chk("mux_user", 64'(m_tuser), 64'(b.u));
          chk("mux_last", 64'(m_tlast), 64'(b.l));
          if (m_tready) begin
            hs_now  = 1'b1;
            hs_src  = m_g;
            hs_data = b.d;
            pop[m_g] = 1'b1;
            m_cnt++;
            if (m_cnt > MAXB) m_over[m_g] = 1'b1;
            if (b.l) begin
              m_last = m_g; m_cnt = 0; m_xfer = 1'b0; m_done = 1'b1;
            end
          end
        end
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NS; i++) if (pop[i]) void'(srcq[i].pop_front());
    drive_srcs();
  endtask

  task automatic do_reset();
    areset = 1'b1;
    cyc();
    cyc();
    areset = 1'b0;
  endtask

  task automatic drain(input int budget);
    int c;
    c = 0;
    m_tready = 1'b1; src_en = '1; gaps = 1'b0;
    drive_srcs();
    while (c < budget && !(all_empty() && !m_xfer)) begin
      cyc();
      c++;
    end
    chk("drain_complete", 64'(all_empty() && !m_xfer), 64'd1);
    cyc();
    cyc();
  endtask

  vec_t t1 [10];
  int   hlog[$];
  logic [DW-1:0] dlog[$];

  initial begin
    int n, nd, c, done_c, g1_c;
    bit added;
    areset = 1'b1; m_tready = 1'b1; src_en = '1; gaps = 1'b0;
    s_tvalid = '0; s_tlast = '0; s_tdata = '0; s_tstrb = '0; s_tuser = '0;

    // 1: all sources hold 1-beat packets -> grants 0,1,2,3,0 two cycles apart
    t1[0] = '{1'b1, 1'b0, 3'd0, 1'b1, 1'b0};
    t1[1] = '{1'b1, 1'b1, 3'd0, 1'b1, 1'b0};
    t1[2] = '{1'b1, 1'b0, 3'd0, 1'b0, 1'b1};
    t1[3] = '{1'b1, 1'b1, 3'd1, 1'b1, 1'b0};
    t1[4] = '{1'b1, 1'b0, 3'd0, 1'b0, 1'b1};
    t1[5] = '{1'b1, 1'b1, 3'd2, 1'b1, 1'b0};
    t1[6] = '{1'b1, 1'b0, 3'd0, 1'b0, 1'b1};
    t1[7] = '{1'b1, 1'b1, 3'd3, 1'b1, 1'b0};
    t1[8] = '{1'b1, 1'b0, 3'd0, 1'b0, 1'b1};
    t1[9] = '{1'b1, 1'b1, 3'd0, 1'b1, 1'b0};
    for (int i = 0; i < NS; i++) begin
      add_pkt(i, 1, 32'(32'h1000 * (i + 1)));
      add_pkt(i, 1, 32'(32'h1100 * (i + 1)));
    end
    drive_srcs();
    cyc();
    cyc();
    areset = 1'b0;
    for (int r = 0; r < 10; r++) begin
      m_tready = t1[r].rdy;
      cyc();
      if (r == 0) chk("t1_reset_overlong", 64'(s_over), 64'd0);
      chk("t1_vld", 64'(s_gvld), 64'(t1[r].vld));
      if (t1[r].cidx) chk("t1_idx", 64'(s_gidx), 64'(t1[r].idx));
      chk("t1_done", 64'(s_done), 64'(t1[r].done));
    end
    drain(100);

    // 2: src1 requests in the middle of src2's 5-beat packet
    add_pkt(2, 5, 32'h2000);
    drive_srcs();
    n = 0; added = 1'b0; done_c = -1; g1_c = -1;
    for (c = 0; c < 30; c++) begin
      cyc();
      if (s_done && done_c < 0) done_c = c;
      if (s_gvld && s_gidx == 3'd1 && g1_c < 0) g1_c = c;
      if (hs_now) begin
        hlog.push_back(hs_src);
        if (hs_src == 2) n++;
      end
      if (n == 2 && !added) begin
        add_pkt(1, 2, 32'h2100);
        drive_srcs();
        added = 1'b1;
      end
    end
    chk("t2_beats", 64'(hlog.size()), 64'd7);
    for (int k = 0; k < 7; k++)
      chk("t2_order", 64'(k < hlog.size() ? hlog[k] : -1), 64'(k < 5 ? 2 : 1));
    chk("t2_regrant_gap", 64'(g1_c - done_c), 64'd1);
    drain(100);

    // 3: egress ready toggling during a 4-beat packet
    add_pkt(0, 4, 32'h3000);
    drive_srcs();
    n = 0; nd = 0;
    for (c = 0; c < 20; c++) begin
      m_tready = (c % 2 == 0);
      cyc();
      if (hs_now) begin
        n++;
        dlog.push_back(hs_data);
      end
      if (s_done) nd++;
    end
    chk("t3_handshakes", 64'(n), 64'd4);
    chk("t3_done_pulses", 64'(nd), 64'd1);
    for (int k = 0; k < 4; k++)
      chk("t3_data_order", 64'(k < dlog.size() ? dlog[k] : '1), 64'(32'h3000 + k));
    drain(100);

    // 4: disabled source is never granted until its enable comes back
    src_en = 4'b1011;
    add_pkt(2, 2, 32'h4000);
    drive_srcs();
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk("t4_no_grant", 64'(s_gvld), 64'd0);
      chk("t4_no_ready", 64'(s_trdy[2]), 64'd0);
    end
    src_en = 4'b1111;
    cyc();
    cyc();
    chk("t4_grant_vld", 64'(s_gvld), 64'd1);
    chk("t4_grant_idx", 64'(s_gidx), 64'd2);
    drain(100);

    // 5: 6-beat packet with MAX_BEATS=4 flags OVERLONG after beat 5
    do_reset();
    add_pkt(0, 6, 32'h5000);
    drive_srcs();
    n = 0;
    for (c = 0; c < 20; c++) begin
      cyc();
      chk("t5_overlong", 64'(s_over), 64'(n >= 5 ? 1 : 0));
      if (hs_now) n++;
    end
    chk("t5_beats", 64'(n), 64'd6);
    do_reset();
    cyc();
    chk("t5_cleared", 64'(s_over), 64'd0);

    // 6: reset in the middle of a packet drops the grant and restarts round-robin at src0
    add_pkt(0, 1, 32'h6000);
    drain(50);
    add_pkt(0, 8, 32'h6100);
    drive_srcs();
    n = 0; c = 0;
    while (n < 3 && c < 30) begin
      cyc();
      if (hs_now) n++;
      c++;
    end
    chk("t6_beats_before_reset", 64'(n), 64'd3);
    areset = 1'b1;
    cyc();
    areset = 1'b0;
    for (int i = 0; i < NS; i++) srcq[i].delete();
    add_pkt(0, 1, 32'h6200);
    add_pkt(1, 1, 32'h6300);
    drive_srcs();
    cyc();
    chk("t6_grant_dropped", 64'(s_gvld), 64'd0);
    chk("t6_ready_dropped", 64'(s_trdy), 64'd0);
    cyc();
    chk("t6_first_vld", 64'(s_gvld), 64'd1);
    chk("t6_first_idx", 64'(s_gidx), 64'd0);
    drain(50);

    // Random traffic against the model
    do_reset();
    gaps = 1'b1;
    for (c = 0; c < 3000; c++) begin
      m_tready = ($urandom_range(9) < 7);
      for (int i = 0; i < NS; i++) begin
        src_en[i] = ($urandom_range(4) != 0);
        if (srcq[i].size() < 6 && $urandom_range(7) == 0)
          add_pkt(i, $urandom_range(7, 1), DW'($urandom));
      end
      cyc();
    end
    drain(3000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
